// File: rtl/islip_if.sv
// Scheduler-side bundle for the iSLIP crossbar scheduler: slot start, the
// request matrix, and the matching/read-strobe results.
interface islip_if #(
  parameter int PORT = 8
);
  logic                   i_start;
  logic [PORT*PORT-1:0]   i_req;
  logic                   o_busy;
  logic                   o_valid;
  logic [PORT*PORT-1:0]   o_match;
  logic [PORT-1:0]        o_rd;
  logic [PORT*PORT-1:0]   o_rd_port;

  modport master (
    output i_start, i_req,
    input  o_busy, o_valid, o_match, o_rd, o_rd_port
  );

  modport slave (
    input  i_start, i_req,
    output o_busy, o_valid, o_match, o_rd, o_rd_port
  );
endinterface

// File: rtl/islip_scheduler.sv
// iSLIP scheduler: ITER request-grant-accept iterations per slot, one per cycle,
// with round-robin grant/accept pointers that only move on first-iteration accepts.
module islip_scheduler #(
  parameter int PORT     = 8,
  parameter int ITER     = 2,
  parameter int PTR_BITS = $clog2(PORT)
) (
  input  logic   clk,
  input  logic   reset,
  islip_if.slave bus
);
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              iter_q;
  logic                          last_iter;
  logic                          valid;
  // Row index is the input, column index the output: x[i][j] <-> bit i*PORT+j.
  logic [PORT-1:0][PORT-1:0]     req_q;
  logic [PORT-1:0][PORT-1:0]     match_q;
  logic [PORT-1:0][PORT-1:0]     match_out_q;
  logic [PORT-1:0][PORT-1:0]     grant;   // grant[j][i]: output j grants input i
  logic [PORT-1:0][PORT-1:0]     accept;  // accept[i][j]: input i accepts output j
  logic [PORT-1:0][PTR_BITS-1:0] g_ptr;
  logic [PORT-1:0][PTR_BITS-1:0] a_ptr;
  logic [PORT-1:0]               in_matched;
  logic [PORT-1:0]               out_matched;

  assign last_iter = (iter_q == CNT_W'(ITER - 1));
  assign valid     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_start) state_d = ITERATE;
      ITERATE: if (last_iter)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_matched  = '0;
    out_matched = '0;
    for (int i = 0; i < PORT; i++) begin
      for (int j = 0; j < PORT; j++) begin
        if (match_q[i][j]) begin
          in_matched[i]  = 1'b1;
          out_matched[j] = 1'b1;
        end
      end
    end
  end

  // Grant: each free output picks the first free requesting input from g_ptr.
  always_comb begin
    logic                gfound;
    logic [PTR_BITS-1:0] idx;
    grant  = '0;
    gfound = 1'b0;
    idx    = '0;
    for (int j = 0; j < PORT; j++) begin
      gfound = 1'b0;
      for (int k = 0; k < PORT; k++) begin
        idx = PTR_BITS'((int'(g_ptr[j]) + k) % PORT);
        if (!gfound && !out_matched[j] && !in_matched[idx] && req_q[idx][j]) begin
          grant[j][idx] = 1'b1;
          gfound        = 1'b1;
        end
      end
    end
  end

  // Accept: each input picks the first granting output from a_ptr.
  always_comb begin
    logic                afound;
    logic [PTR_BITS-1:0] jdx;
    accept = '0;
    afound = 1'b0;
    jdx    = '0;
    for (int i = 0; i < PORT; i++) begin
      afound = 1'b0;
      for (int k = 0; k < PORT; k++) begin
        jdx = PTR_BITS'((int'(a_ptr[i]) + k) % PORT);
        if (!afound && grant[jdx][i]) begin
          accept[i][jdx] = 1'b1;
          afound         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      req_q       <= '0;
      match_q     <= '0;
      match_out_q <= '0;
      g_ptr       <= '0;
      a_ptr       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            req_q       <= bus.i_req;
            match_q     <= '0;
            match_out_q <= '0;
            iter_q      <= '0;
          end
        end
        ITERATE: begin
          match_q <= match_q | accept;
          iter_q  <= iter_q + 1'b1;
          // Only the complete matching is published, never a partial one.
          if (last_iter) match_out_q <= match_q | accept;
          if (iter_q == '0) begin
            for (int i = 0; i < PORT; i++) begin
              for (int j = 0; j < PORT; j++) begin
                if (accept[i][j]) begin
                  a_ptr[i] <= PTR_BITS'((j + 1) % PORT);
                  g_ptr[j] <= PTR_BITS'((i + 1) % PORT);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_rd = '0;
    for (int i = 0; i < PORT; i++) begin
      bus.o_rd[i] = valid & (|match_out_q[i]);
    end
  end

  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_valid   = valid;
  assign bus.o_match   = match_out_q;
  assign bus.o_rd_port = valid ? match_out_q : '0;

endmodule

// File: tb/tb_islip_scheduler.sv
// Directed bench for islip_scheduler with PORT=4, ITER=2; expected matchings
// and pointer values are worked out by hand from the iSLIP rules.
module tb_islip_scheduler;
  localparam int PORT = 4;
  localparam int ITER = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  islip_if #(.PORT(PORT)) bus ();

  islip_scheduler #(.PORT(PORT), .ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one slot; returns latency (99 on timeout), results during DONE and
  // the output state one cycle after DONE.
  task automatic run_slot(input logic [15:0] req, output int lat,
                          output logic [15:0] match, output logic [3:0] rd,
                          output logic [15:0] rd_port, output logic valid_after,
                          output logic [3:0] rd_after, output logic [15:0] match_after);
    lat         = 99;
    match       = 'x;
    rd          = 'x;
    rd_port     = 'x;
    bus.i_req   = req;
    bus.i_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.i_start = 1'b0;
      if (bus.o_valid) begin
        lat     = c;
        match   = bus.o_match;
        rd      = bus.o_rd;
        rd_port = bus.o_rd_port;
        break;
      end
    end
    tick();
    valid_after = bus.o_valid;
    rd_after    = bus.o_rd | bus.o_rd_port[3:0] | bus.o_rd_port[7:4]
                | bus.o_rd_port[11:8] | bus.o_rd_port[15:12];
    match_after = bus.o_match;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.i_start = 1'b1;
    bus.i_req   = 16'hFFFF;
    tick();
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b valid=%b required 0 0", bus.o_busy, bus.o_valid);
    end
    checks++;
    if (bus.o_match !== 16'h0 || bus.o_rd !== 4'h0 || bus.o_rd_port !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: match=%h rd=%b rd_port=%h required 0", bus.o_match, bus.o_rd, bus.o_rd_port);
    end
    checks++;
    if (dut.g_ptr !== 8'h00 || dut.a_ptr !== 8'h00) begin
      failures++;
      $display("FAIL reset_ptr: g=%h a=%h required 00 00", dut.g_ptr, dut.a_ptr);
    end
    bus.i_start = 1'b0;
    reset       = 1'b0;
    tick();
    checks++;
    if (bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_slot: busy=%b required 0", bus.o_busy);
    end
  endtask

  task automatic check_slot(input string name, input logic [15:0] req,
                            input logic [15:0] exp_match, input logic [3:0] exp_rd,
                            input logic [7:0] exp_g, input logic [7:0] exp_a);
    int lat;
    logic [15:0] match, rd_port, match_after;
    logic [3:0] rd, rd_after;
    logic valid_after;
    run_slot(req, lat, match, rd, rd_port, valid_after, rd_after, match_after);
    checks++;
    if (lat !== ITER + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, ITER + 1);
    end
    checks++;
    if (match !== exp_match || rd_port !== exp_match) begin
      failures++;
      $display("FAIL %s_match: match=%h rd_port=%h required %h", name, match, rd_port, exp_match);
    end
    checks++;
    if (rd !== exp_rd) begin
      failures++;
      $display("FAIL %s_rd: got %b required %b", name, rd, exp_rd);
    end
    checks++;
    if (valid_after !== 1'b0 || rd_after !== 4'h0 || match_after !== exp_match) begin
      failures++;
      $display("FAIL %s_after: valid=%b rd/rd_port=%b match=%h required 0 0 %h",
               name, valid_after, rd_after, match_after, exp_match);
    end
    checks++;
    if (dut.g_ptr !== exp_g || dut.a_ptr !== exp_a) begin
      failures++;
      $display("FAIL %s_ptr: g=%h a=%h required %h %h", name, dut.g_ptr, dut.a_ptr, exp_g, exp_a);
    end
  endtask

  task automatic test_full_load_slot1();
    check_slot("full1", 16'hFFFF, 16'h0021, 4'b0011, 8'h01, 8'h01);
  endtask

  task automatic test_full_load_slot2();
    int lat;
    logic [15:0] match, rd_port, match_after;
    logic [3:0] rd, rd_after;
    logic valid_after;
    run_slot(16'hFFFF, lat, match, rd, rd_port, valid_after, rd_after, match_after);
    checks++;
    if (match !== 16'h0412 || rd !== 4'b0111) begin
      failures++;
      $display("FAIL full2_match: match=%h rd=%b required 0412 0111", match, rd);
    end
    checks++;
    if (rd_port[3:0] !== 4'b0010) begin
      failures++;
      $display("FAIL full2_rd_port_row0: got %b required 0010", rd_port[3:0]);
    end
    checks++;
    if (dut.g_ptr !== 8'h06 || dut.a_ptr !== 8'h06) begin
      failures++;
      $display("FAIL full2_ptr: g=%h a=%h required 06 06", dut.g_ptr, dut.a_ptr);
    end
  endtask

  task automatic test_no_requests();
    check_slot("empty", 16'h0000, 16'h0000, 4'b0000, 8'h06, 8'h06);
  endtask

  task automatic test_wrap();
    check_slot("wrap", 16'h8000, 16'h8000, 4'b1000, 8'h06, 8'h06);
  endtask

  task automatic test_req_sampled_once();
    logic [15:0] match;
    int lat;
    lat         = 99;
    match       = 'x;
    bus.i_req   = 16'h0000;
    bus.i_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.i_start = 1'b0;
      bus.i_req   = 16'hFFFF;
      if (bus.o_valid) begin
        lat   = c;
        match = bus.o_match;
        break;
      end
    end
    tick();
    checks++;
    if (lat !== ITER + 1 || match !== 16'h0000 || dut.g_ptr !== 8'h06) begin
      failures++;
      $display("FAIL req_sampled_once: lat=%0d match=%h g=%h required 3 0000 06", lat, match, dut.g_ptr);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, idle_cycles, last_pulse, bad_gap;
    pulses      = 0;
    idle_cycles = 0;
    last_pulse  = -1;
    bad_gap     = 0;
    bus.i_req   = 16'h0000;
    bus.i_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.o_valid) begin
        if (last_pulse >= 0 && c - last_pulse != ITER + 2) bad_gap++;
        last_pulse = c;
        pulses++;
      end
      if (!bus.o_busy) idle_cycles++;
    end
    bus.i_start = 1'b0;
    for (int c = 0; c < 8 && bus.o_busy; c++) tick();
    checks++;
    if (pulses !== 4 || bad_gap !== 0) begin
      failures++;
      $display("FAIL back_to_back_pulses: pulses=%0d bad_gaps=%0d required 4 0", pulses, bad_gap);
    end
    checks++;
    if (idle_cycles !== 4) begin
      failures++;
      $display("FAIL back_to_back_idle: idle cycles=%0d required 4", idle_cycles);
    end
  endtask

  task automatic test_reset_mid_slot();
    int saw_valid;
    saw_valid   = 0;
    bus.i_req   = 16'hFFFF;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy: got %b required 1", bus.o_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.o_valid) saw_valid++;
      tick();
    end
    checks++;
    if (saw_valid !== 0 || bus.o_busy !== 1'b0 || bus.o_match !== 16'h0) begin
      failures++;
      $display("FAIL midreset_state: valid pulses=%0d busy=%b match=%h required 0 0 0000",
               saw_valid, bus.o_busy, bus.o_match);
    end
    checks++;
    if (dut.g_ptr !== 8'h00 || dut.a_ptr !== 8'h00) begin
      failures++;
      $display("FAIL midreset_ptr: g=%h a=%h required 00 00", dut.g_ptr, dut.a_ptr);
    end
    check_slot("after_reset", 16'hFFFF, 16'h0021, 4'b0011, 8'h01, 8'h01);
  endtask

  initial begin
    reset       = 1'b1;
    bus.i_start = 1'b0;
    bus.i_req   = '0;
    test_reset();
    test_full_load_slot1();
    test_full_load_slot2();
    test_no_requests();
    test_wrap();
    test_req_sampled_once();
    test_back_to_back();
    test_reset_mid_slot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/islip_scheduler.md
Name: islip_scheduler

Overview:
- Per-slot iSLIP crossbar scheduler for a PORT x PORT input-queued switch.
- Each input's VOQ bank reports non-empty status per output. The scheduler runs ITER request-grant-accept iterations with round-robin grant and accept pointers.
- It emits one conflict-free matching per slot, plus per-input read strobes that drive each VOQ bank's read handshake (rd, one-hot rd_port).

Parameters:
- PORT, 8, number of switch inputs and outputs (>=2).
- ITER, 2, iSLIP iterations per slot (>=1).
- PTR_BITS, $clog2(PORT), width of each round-robin pointer.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- i_start  input  1  start a scheduling slot; sampled only in IDLE.
- i_req  input  PORT*PORT  bit [i*PORT+j] = input i has a cell for output j.
- o_busy  output  1  high in ITERATE and DONE.
- o_valid  output  1  one-cycle pulse: o_match, o_rd and o_rd_port are valid.
- o_match  output  PORT*PORT  bit [i*PORT+j] = input i matched to output j.
- o_rd  output  PORT  per-input VOQ read strobe; equals OR of row i of o_match, qualified by o_valid.
- o_rd_port  output  PORT*PORT  [i*PORT +: PORT] = one-hot output selected for input i; zero if unmatched.

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on posedge clk.
  - Reset is synchronous, active-high, and dominates every other input.
- Reset values:
  - o_busy=0, o_valid=0, o_match=0, o_rd=0, o_rd_port=0.
  - All grant pointers g[j]=0, all accept pointers a[i]=0.
  - FSM=IDLE, iteration counter=0.
- FSM states: IDLE, ITERATE, DONE.
  - IDLE: when i_start=1, register i_req into req_q, clear the match register and the counter, then go to ITERATE. Otherwise stay in IDLE.
  - ITERATE: perform one full iteration per cycle. After ITER iterations, go to DONE.
  - DONE: assert o_valid, o_rd and o_rd_port for exactly one cycle, then go to IDLE.
  - i_start is ignored outside IDLE.
- Latency: o_valid rises exactly ITER+1 cycles after the cycle in which i_start is sampled. The next slot can start the cycle after DONE, so the minimum slot period is ITER+2 cycles.
- Iteration (combinational within one cycle, registered at the edge):
  - Only unmatched inputs and unmatched outputs participate.
  - Grant: each unmatched output j grants the first input i, searching cyclically from g[j], such that req_q[i*PORT+j]=1 and input i is unmatched.
  - Accept: each unmatched input i accepts the first granting output, searching cyclically from a[i].
  - Accepted pairs are ORed into the match register.
- Pointer update (first iteration only, only for accepted pairs):
  - g[j] <= (i+1) mod PORT.
  - a[i] <= (j+1) mod PORT.
  - Wrap: PORT-1 advances to 0.
  - Non-accepted grants leave pointers unchanged.
  - Iterations 2..ITER never modify pointers.
- Match invariant: at most one bit set per row and per column of o_match. Outputs never carry a partial matching.
- Empty slot: if req_q=0, DONE still pulses o_valid with o_match=0, o_rd=0, and pointers unchanged.
- o_match holds its value after DONE until the next i_start. o_rd and o_rd_port are zero outside DONE.
- o_busy is high in ITERATE and DONE.
- Reset mid-slot: return to IDLE next edge. No o_valid pulse occurs, the match register is cleared, and pointers are cleared.
- Requests are sampled once per slot; i_req changes during ITERATE or DONE have no effect.

Test Plan:
- Reset with PORT=4, ITER=2: reset held 2 cycles -> all outputs 0, all pointers 0, o_busy=0. i_start during reset -> no slot begins.
- Full load, slot 1: PORT=4, ITER=2, i_req=all ones, i_start -> o_valid 3 cycles later.
  - Matches 0->0 and 1->1; o_rd=4'b0011.
  - Pointers afterwards: g[0]=1, a[0]=1, all others 0.
- Full load, slot 2 (same i_req) -> matches 0->1, 1->0, 2->2; o_rd=4'b0111; o_rd_port row0=4'b0010.
- No requests: i_req=0, i_start -> o_valid pulse with o_match=0, o_rd=0; pointers unchanged.
- Wrap and busy:
  - Only input 3 requests output 3 with g[3]=0, a[3]=0 -> match 3->3, g[3]=0 and a[3]=0 (wrap).
  - i_start asserted every cycle -> slots start only every ITER+2 cycles.
- Reset mid-slot: assert reset during ITERATE -> no o_valid pulse, FSM returns to IDLE, pointers cleared, next slot behaves as the first full-load slot.
